uart_int_ctrl: RTL
==================

UART_INT_CTRL -- requirements
Module: uart_int_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 7, number of status interrupt sources.
REQ-002 SHALL have parameter HOLDOFF, default 2, number of idle cycles forced after each acknowledge (1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port status, input, NSRC, registered UART status bits: 0 fe, 1 crce, 2 ore, 3 nf, 4 txi, 5 tbnf, 6 dr.
REQ-006 SHALL have port mask_we, input, 1, write strobe for the enable mask.
REQ-007 SHALL have port mask_wdata, input, NSRC, new enable mask value.
REQ-008 SHALL have port ack, input, 1, acknowledge from the interrupt consumer.
REQ-009 SHALL have port irq, output, 1, interrupt request.
REQ-010 SHALL have port irq_id, output, 3, index of the source in service; valid only while irq=1.
REQ-011 SHALL have port pending, output, NSRC, latched pending bits.
REQ-012 SHALL have port mask, output, NSRC, current enable mask.

Function
REQ-013 SHALL register status once (status_q) and detect rising edges as status & ~status_q.
REQ-014 SHALL set pending[i] on a rising edge of status[i], whatever mask[i] is.
REQ-015 SHALL load mask from mask_wdata on the cycle after mask_we=1.
REQ-016 SHALL define a candidate as pending & mask, with fixed priority: lowest index wins (fe highest, dr lowest).
REQ-017 SHALL use FSM states IDLE, ACTIVE and HOLD.
REQ-018 In IDLE with any candidate, SHALL go to ACTIVE, latch the winning index into irq_id, and assert irq on the next edge (1-cycle latency from the pending edge to irq).
REQ-019 In ACTIVE, SHALL hold irq=1 and irq_id stable until ack=1, including when mask_we clears that source's mask bit.
REQ-020 On ack=1 in ACTIVE, SHALL clear pending[irq_id], drop irq the next cycle, load the holdoff counter with HOLDOFF-1, and go to HOLD.
REQ-021 In HOLD, SHALL decrement the counter each cycle, keep irq=0, and go to IDLE when the counter is 0.
REQ-022 SHALL ignore ack in IDLE and in HOLD.
REQ-023 If a rising edge on source k coincides with ack clearing pending[k], set SHALL win and pending[k] stays 1.
REQ-024 If sources have simultaneous rising edges, SHALL set all their pending bits in the same cycle; service follows REQ-016, one per ACTIVE episode.
REQ-025 SHALL only ever clear pending bits through ack; a falling status level has no effect.
REQ-026 SHALL drive irq_id to 0 whenever irq=0.

Reset
REQ-027 While reset=1, SHALL set asynchronously: state=IDLE, irq=0, irq_id=0, pending=0, mask=0, status_q=0, counter=0.
REQ-028 Reset asserted during ACTIVE or HOLD SHALL abandon service; after release, status bits already high do not count as rising edges until they fall and rise again.
REQ-029 SHALL accept a reset release asynchronous to clk; behaviour is defined from the first clk edge after release.

Structure
REQ-030 SHALL use shared package uart_pkg holding: the FSM state enum; localparams for source indices FE=0, CRCE=1, ORE=2, NF=3, TXI=4, TBNF=5, DR=6; and NSRC_DEFAULT=7.
REQ-031 SHALL put the lowest-index-first priority encoder (candidate vector in, 3-bit index and valid out) in one combinational sub-module named uart_int_prio.
REQ-032 SHALL instantiate the status register upstream, not inside this block.

Verification
REQ-033 mask=7'h7F; status goes 0->0x40 -> pending=0x40, irq=1 with irq_id=6 one cycle later; ack -> irq=0 and pending=0; no irq for 2 cycles.
REQ-034 mask=7'h7F; status goes 0->0x05 in one cycle -> irq_id=0; after ack and holdoff, irq_id=2; after the second ack, pending=0.
REQ-035 mask=7'h00; status rises on bit 2 -> pending=0x04 and irq stays 0; then write mask=0x04 -> irq=1 with irq_id=2.
REQ-036 In ACTIVE with irq_id=3, status[3] falls and rises again on the same cycle as ack -> pending[3] remains 1; irq is reasserted with irq_id=3 after holdoff.
REQ-037 reset pulsed during ACTIVE while status=0x01 is held high -> irq=0 and pending=0 immediately; no irq after release until status[0] toggles.
REQ-038 ack pulsed in IDLE with pending=0 -> no state change and irq stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART interrupt controller
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } int_state_e;

  localparam int FE   = 0;
  localparam int CRCE = 1;
  localparam int ORE  = 2;
  localparam int NF   = 3;
  localparam int TXI  = 4;
  localparam int TBNF = 5;
  localparam int DR   = 6;

  localparam int NSRC_DEFAULT = 7;

endpackage

// File: rtl/uart_int_prio.sv
// rtl/uart_int_prio.sv - lowest-index-first priority encoder over the candidate vector
module uart_int_prio #(
  parameter int N = 7
) (
  input  logic [N-1:0] cand,
  output logic [2:0]   idx,
  output logic         valid
);

  // Scan from the top down so the lowest set index is the last to write.
  always_comb begin
    idx   = 3'd0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_int_ctrl.sv
// rtl/uart_int_ctrl.sv - UART status interrupt latch, mask and single-request service FSM
module uart_int_ctrl
  import uart_pkg::*;
#(
  parameter int NSRC    = NSRC_DEFAULT,
  parameter int HOLDOFF = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] status,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            ack,
  output logic            irq,
  output logic [2:0]      irq_id,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask
);

  localparam logic [3:0]      HOLD_INIT = 4'(HOLDOFF - 1);
  localparam logic [NSRC-1:0] ONE       = {{(NSRC-1){1'b0}}, 1'b1};

  int_state_e      state_q, state_d;
  logic [NSRC-1:0] status_q, status_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic            armed_q, armed_d;
  logic            irq_q, irq_d;
  logic [2:0]      irq_id_q, irq_id_d;
  logic [3:0]      cnt_q, cnt_d;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] cand;
  logic [2:0]      win_id;
  logic            win_valid;
  logic            ack_take;

  // armed_q stays low for the first edge after reset so levels already high
  // at release are absorbed into status_q instead of looking like new edges.
  always_comb begin
    status_d = status;
    armed_d  = 1'b1;
    rise     = armed_q ? (status & ~status_q) : '0;
    mask_d   = mask_we ? mask_wdata : mask_q;
  end

  always_comb begin
    ack_take  = (state_q == ST_ACTIVE) && ack;
    clr       = ack_take ? (ONE << irq_id_q) : '0;
    pending_d = (pending_q & ~clr) | rise;
    cand      = pending_q & mask_q;
  end

  uart_int_prio #(
    .N (NSRC)
  ) u_prio (
    .cand  (cand),
    .idx   (win_id),
    .valid (win_valid)
  );

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    irq_id_d = irq_id_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d  = ST_ACTIVE;
          irq_d    = 1'b1;
          irq_id_d = win_id;
        end
      end
      ST_ACTIVE: begin
        // Mask changes are ignored here: the source in service is committed.
        if (ack) begin
          state_d  = ST_HOLD;
          irq_d    = 1'b0;
          irq_id_d = 3'd0;
          cnt_d    = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        irq_d    = 1'b0;
        irq_id_d = 3'd0;
        cnt_d    = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      status_q  <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      armed_q   <= 1'b0;
      irq_q     <= 1'b0;
      irq_id_q  <= 3'd0;
      cnt_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      armed_q   <= armed_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
      cnt_q     <= cnt_d;
    end
  end

  assign irq     = irq_q;
  assign irq_id  = irq_q ? irq_id_q : 3'd0;
  assign pending = pending_q;
  assign mask    = mask_q;

endmodule
